// File: rtl/pwm_duty_ramp_ctrl_pkg.sv
// Shared types and constants for the PWM duty controllers.
// Used by the ramp controller and future PWM channel modules.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] RST_DUTY_DFLT = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target-duty valid/ready handshake bundle.
// The master offers a duty; the controller (slave) accepts it.
interface pwm_duty_ramp_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic              tgt_valid;
  logic [DUTY_W-1:0] tgt_duty;
  logic              tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_duty,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    output tgt_ready
  );

endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty ramp sequencer: walks Dout toward an accepted target
// in STEP increments, one step every DIV PWM periods.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int                STEP     = 1,
  parameter int                DIV      = 4,
  parameter logic [DUTY_W-1:0] RST_DUTY = RST_DUTY_DFLT
) (
  input  logic              CLK,
  input  logic              RSTin,
  input  logic              enable,
  input  logic              per_end,
  input  logic              abort,
  pwm_duty_ramp_ctrl_if.slave tgt,
  output logic [DUTY_W-1:0] Dout,
  output logic              busy,
  output logic              done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DUTY_W:0] STEP9 = (DUTY_W+1)'(STEP);

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [DUTY_W-1:0] tgt_q;
  logic              pe;
  logic              q;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_lim;
  logic              accept;

  assign pe     = enable & per_end;
  assign q      = pe & (div_cnt == DIV_LAST);
  assign up_sum = {1'b0, Dout} + STEP9;
  assign dn_lim = {1'b0, tgt_q} + STEP9;
  assign accept = tgt.tgt_valid & tgt.tgt_ready;

  // Ramp FSM with registered duty, handshake and status outputs
  always_ff @(posedge CLK) begin
    if (RSTin) begin
      state         <= IDLE;
      Dout          <= RST_DUTY;
      tgt_q         <= RST_DUTY;
      div_cnt       <= '0;
      tgt.tgt_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tgt_q   <= tgt.tgt_duty;
            div_cnt <= '0;
            if (tgt.tgt_duty > Dout) begin
              state         <= RAMP_UP;
              tgt.tgt_ready <= 1'b0;
              busy          <= 1'b1;
            end else if (tgt.tgt_duty < Dout) begin
              state         <= RAMP_DOWN;
              tgt.tgt_ready <= 1'b0;
              busy          <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (abort) begin
            state         <= IDLE;
            div_cnt       <= '0;
            tgt.tgt_ready <= 1'b1;
            busy          <= 1'b0;
          end else if (q) begin
            div_cnt <= '0;
            if ((state == RAMP_UP && up_sum >= {1'b0, tgt_q}) ||
                (state == RAMP_DOWN && {1'b0, Dout} < dn_lim)) begin
              Dout          <= tgt_q;
              state         <= IDLE;
              tgt.tgt_ready <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else if (state == RAMP_UP) begin
              Dout <= up_sum[DUTY_W-1:0];
            end else begin
              Dout <= Dout - STEP9[DUTY_W-1:0];
            end
          end else if (pe) begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl.
// Unit A: STEP=1 DIV=4. Unit B: STEP=10 DIV=1 with a Dout scoreboard.
module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       enable;
  logic       abort;
  logic       pe_a, pe_b;
  logic [7:0] dout_a, dout_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_b;

  pwm_duty_ramp_ctrl_if if_a ();
  pwm_duty_ramp_ctrl_if if_b ();

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(.STEP(1), .DIV(4), .RST_DUTY(8'd128)) dut_a (
    .CLK     (clk),
    .RSTin   (rst_a),
    .enable  (enable),
    .per_end (pe_a),
    .abort   (abort),
    .tgt     (if_a),
    .Dout    (dout_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  pwm_duty_ramp_ctrl #(.STEP(10), .DIV(1), .RST_DUTY(8'd128)) dut_b (
    .CLK     (clk),
    .RSTin   (rst_b),
    .enable  (enable),
    .per_end (pe_b),
    .abort   (1'b0),
    .tgt     (if_b),
    .Dout    (dout_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(int n);
    for (int i = 0; i < n; i++) begin
      pe_a = 1'b1;
      step();
      pe_a = 1'b0;
      step();
    end
  endtask

  task automatic pulse_b(int n);
    for (int i = 0; i < n; i++) begin
      pe_b = 1'b1;
      step();
      pe_b = 1'b0;
    end
  endtask

  // Scoreboard: every Dout change of unit B must match the next expected value
  always @(negedge clk) begin
    if (mon_en && dout_b !== prev_b) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {1'b0, dout_b}, 9'h1ff);
      end else begin
        chk("sb_dout_b", {1'b0, dout_b}, {1'b0, sb_q.pop_front()});
      end
      prev_b = dout_b;
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    enable = 1'b1;
    abort = 1'b0;
    pe_a = 1'b0;
    pe_b = 1'b0;
    if_a.tgt_valid = 1'b0;
    if_a.tgt_duty = '0;
    if_b.tgt_valid = 1'b0;
    if_b.tgt_duty = '0;
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // reset state
    chk("rst_dout", {1'b0, dout_a}, 9'd128);
    chk("rst_ready", {8'd0, if_a.tgt_ready}, 9'd1);
    chk("rst_busy", {8'd0, busy_a}, 9'd0);
    chk("rst_done", {8'd0, done_a}, 9'd0);
    prev_b = 8'd128;
    mon_en = 1'b1;

    // target equal to present duty
    if_b.tgt_valid = 1'b1;
    if_b.tgt_duty = 8'd128;
    step();
    if_b.tgt_valid = 1'b0;
    chk("eq_busy", {8'd0, busy_b}, 9'd0);
    chk("eq_done", {8'd0, done_b}, 9'd1);
    chk("eq_dout", {1'b0, dout_b}, 9'd128);
    chk("eq_ready", {8'd0, if_b.tgt_ready}, 9'd1);
    step();
    chk("eq_done_end", {8'd0, done_b}, 9'd0);

    // STEP=10 up to 250 with clamp
    for (int v = 138; v <= 248; v += 10) sb_q.push_back(8'(v));
    sb_q.push_back(8'd250);
    if_b.tgt_valid = 1'b1;
    if_b.tgt_duty = 8'd250;
    step();
    if_b.tgt_valid = 1'b0;
    chk("b_up_busy", {8'd0, busy_b}, 9'd1);
    chk("b_up_ready", {8'd0, if_b.tgt_ready}, 9'd0);
    pulse_b(13);
    chk("b_up_done", {8'd0, done_b}, 9'd1);
    chk("b_up_final", {1'b0, dout_b}, 9'd250);
    step();

    // STEP=10 down to 3 with clamp
    for (int v = 240; v >= 10; v -= 10) sb_q.push_back(8'(v));
    sb_q.push_back(8'd3);
    if_b.tgt_valid = 1'b1;
    if_b.tgt_duty = 8'd3;
    step();
    if_b.tgt_valid = 1'b0;
    pulse_b(25);
    chk("b_dn_done", {8'd0, done_b}, 9'd1);
    chk("b_dn_final", {1'b0, dout_b}, 9'd3);
    pulse_b(2);
    step();
    chk("sb_empty", 9'(sb_q.size()), 9'd0);

    // STEP=1 DIV=4 ramp 128 -> 132
    if_a.tgt_valid = 1'b1;
    if_a.tgt_duty = 8'd132;
    step();
    if_a.tgt_valid = 1'b0;
    chk("a_busy", {8'd0, busy_a}, 9'd1);
    chk("a_ready_lo", {8'd0, if_a.tgt_ready}, 9'd0);
    pulse_a(3);
    chk("a_3rd", {1'b0, dout_a}, 9'd128);
    pulse_a(1);
    chk("a_4th", {1'b0, dout_a}, 9'd129);
    pulse_a(11);
    chk("a_15th", {1'b0, dout_a}, 9'd131);
    pe_a = 1'b1;
    step();
    pe_a = 1'b0;
    chk("a_16th", {1'b0, dout_a}, 9'd132);
    chk("a_done", {8'd0, done_a}, 9'd1);
    chk("a_ready_done", {8'd0, if_a.tgt_ready}, 9'd1);
    chk("a_busy_done", {8'd0, busy_a}, 9'd0);
    step();
    chk("a_done_end", {8'd0, done_a}, 9'd0);

    // abort coincident with a step at 140
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    if_a.tgt_valid = 1'b1;
    if_a.tgt_duty = 8'd200;
    step();
    if_a.tgt_valid = 1'b0;
    pulse_a(48);
    chk("ab_pre", {1'b0, dout_a}, 9'd140);
    pulse_a(3);
    pe_a = 1'b1;
    abort = 1'b1;
    step();
    pe_a = 1'b0;
    abort = 1'b0;
    chk("ab_dout", {1'b0, dout_a}, 9'd140);
    chk("ab_busy", {8'd0, busy_a}, 9'd0);
    chk("ab_done", {8'd0, done_a}, 9'd0);
    chk("ab_ready", {8'd0, if_a.tgt_ready}, 9'd1);
    if_a.tgt_valid = 1'b1;
    if_a.tgt_duty = 8'd120;
    step();
    if_a.tgt_valid = 1'b0;
    chk("ab_new_busy", {8'd0, busy_a}, 9'd1);

    // enable low freezes divider and duty
    pulse_a(2);
    enable = 1'b0;
    pulse_a(3);
    chk("frz_dout", {1'b0, dout_a}, 9'd140);
    enable = 1'b1;
    pulse_a(1);
    chk("frz_div", {1'b0, dout_a}, 9'd140);
    pulse_a(1);
    chk("frz_resume", {1'b0, dout_a}, 9'd139);

    // reset mid-ramp
    pulse_a(2);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mr_dout", {1'b0, dout_a}, 9'd128);
    chk("mr_busy", {8'd0, busy_a}, 9'd0);
    chk("mr_ready", {8'd0, if_a.tgt_ready}, 9'd1);
    pulse_a(4);
    chk("mr_hold", {1'b0, dout_a}, 9'd128);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
